// File: rtl/i2c_cfg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2c_cfg_seq                                            |
// | Description : Walks an external table of 16-bit words and writes     |
// |               each one to a single I2C slave as a 3-byte frame       |
// |               {DEV_ADDR+W, word[15:8], word[7:0]}, with STOP,        |
// |               bounded per-entry retry on NACK and error reporting.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2c_cfg_seq #(
  parameter int unsigned DIV         = 125,
  parameter int unsigned NUM_ENTRIES = 10,
  parameter int unsigned IDX_W       = 4,
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned MAX_RETRY   = 3,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [IDX_W-1:0] tbl_index,
  input  logic [15:0]      tbl_data,
  output logic             i2c_sclk,
  inout  wire              i2c_sdat
);

  localparam int unsigned       c_DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
  localparam int unsigned       c_RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]  c_IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_DIV_W-1:0]   r_div;
  logic [1:0]           r_q;          // quarter-period phase within a bus phase
  logic                 r_launch;     // one-shot launch request after reset
  logic [23:0]          r_sh;         // frame bits, MSB on the wire first
  logic [3:0]           r_bcnt;       // bit slot within byte, 8 = ACK slot
  logic [1:0]           r_byte;       // byte within frame
  logic                 r_nack;
  logic [1:0]           r_sda_sync;
  logic [c_RTY_W-1:0]   r_retry;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_err_idx;

  logic w_run, w_tick, w_qend, w_go, w_ack_slot, w_last_idx, w_retry_ok;
  logic w_scl, w_sda_low;

  assign w_run      = (r_state == S_START) || (r_state == S_BIT) ||
                      (r_state == S_STOP)  || (r_state == S_GAP);
  assign w_tick     = w_run && (r_div == c_DIV_LAST);
  assign w_qend     = w_tick && (r_q == 2'd3);
  // start is only honoured outside a running sequence
  assign w_go       = !w_run && (start || r_launch);
  assign w_ack_slot = (r_bcnt == 4'd8);
  assign w_last_idx = (r_idx == c_IDX_LAST);
  assign w_retry_ok = (r_retry < c_RTY_MAX);

  assign busy      = w_run;
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERROR);
  assign err_index = r_err_idx;
  assign tbl_index = r_idx;
  assign i2c_sclk  = w_scl;
  assign i2c_sdat  = w_sda_low ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and bus pin decode
  always_comb begin
    w_state_nxt = r_state;
    w_scl       = 1'b1;
    w_sda_low   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_go) w_state_nxt = S_START;
      end
      S_START: begin
        w_scl     = (r_q < 2'd2);
        w_sda_low = (r_q != 2'd0);
        if (w_qend) w_state_nxt = S_BIT;
      end
      S_BIT: begin
        w_scl     = (r_q == 2'd1) || (r_q == 2'd2);
        w_sda_low = !w_ack_slot && !r_sh[23];
        if (w_qend && w_ack_slot && (r_nack || (r_byte == 2'd2)))
          w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_scl     = (r_q != 2'd0);
        w_sda_low = (r_q < 2'd2);
        if (w_qend) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_qend) begin
          if (r_nack)          w_state_nxt = w_retry_ok ? S_START : S_ERROR;
          else if (w_last_idx) w_state_nxt = S_DONE;
          else                 w_state_nxt = S_START;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Quarter-tick timebase, only running while a frame sequence is active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_q   <= 2'd0;
    end else if (!w_run) begin
      r_div <= '0;
      r_q   <= 2'd0;
    end else if (w_tick) begin
      r_div <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Frame shifter, slot counters and ACK sampling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh       <= '0;
      r_bcnt     <= 4'd0;
      r_byte     <= 2'd0;
      r_nack     <= 1'b0;
      r_sda_sync <= 2'b11;
    end else begin
      r_sda_sync <= {r_sda_sync[0], i2c_sdat};
      if (w_go) begin
        r_nack <= 1'b0;
      end else if (r_state == S_START && w_tick && r_q == 2'd0) begin
        // tbl_index is settled by now, so the word on tbl_data is valid
        r_sh   <= {DEV_ADDR, 1'b0, tbl_data};
        r_bcnt <= 4'd0;
        r_byte <= 2'd0;
        r_nack <= 1'b0;
      end else if (r_state == S_BIT && w_tick) begin
        if (w_ack_slot && r_q == 2'd2 && r_sda_sync[1])
          r_nack <= 1'b1;
        if (r_q == 2'd3) begin
          if (w_ack_slot) begin
            r_bcnt <= 4'd0;
            r_byte <= r_byte + 2'd1;
          end else begin
            r_bcnt <= r_bcnt + 4'd1;
            r_sh   <= {r_sh[22:0], 1'b0};
          end
        end
      end
    end
  end

  // Table index, retry counter, failing-entry capture and reset launch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_retry   <= '0;
      r_err_idx <= '0;
      r_launch  <= AUTO_START;
    end else begin
      r_launch <= 1'b0;
      if (w_go) begin
        r_idx     <= '0;
        r_retry   <= '0;
        r_err_idx <= '0;
      end else if (r_state == S_GAP && w_qend) begin
        if (r_nack) begin
          if (w_retry_ok) r_retry   <= r_retry + 1'b1;
          else            r_err_idx <= r_idx;
        end else if (!w_last_idx) begin
          r_idx   <= r_idx + 1'b1;
          r_retry <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_i2c_cfg_seq                                         |
// | Description : Directed bench for i2c_cfg_seq with a bus monitor and  |
// |               an ACK/NACK-programmable slave model.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_i2c_cfg_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, start2;
  logic        busy, done, error, busy2, done2, error2;
  logic [3:0]  err_index, tbl_index, err_index2, tbl_index2;
  logic [15:0] tbl_data;
  logic [15:0] tbl_data2;
  logic        i2c_sclk, i2c_sclk2;
  wire         i2c_sdat;
  wire         i2c_sdat2;
  logic        slave_low = 1'b0;

  int n_tot = 0;
  int n_bad = 0;
  int cur   = 0;
  int cyc   = 0;

  pullup (i2c_sdat);
  pullup (i2c_sdat2);
  assign i2c_sdat  = slave_low ? 1'b0 : 1'bz;
  assign tbl_data2 = 16'hA55A;

  i2c_cfg_seq #(.DIV(4), .NUM_ENTRIES(3), .IDX_W(4), .DEV_ADDR(7'h1A),
                .MAX_RETRY(2), .AUTO_START(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .tbl_index(tbl_index),
    .tbl_data(tbl_data), .i2c_sclk(i2c_sclk), .i2c_sdat(i2c_sdat));

  i2c_cfg_seq #(.DIV(4), .NUM_ENTRIES(3), .IDX_W(4), .DEV_ADDR(7'h1A),
                .MAX_RETRY(2), .AUTO_START(1'b0)) u_dut_man (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .error(error2), .err_index(err_index2), .tbl_index(tbl_index2),
    .tbl_data(tbl_data2), .i2c_sclk(i2c_sclk2), .i2c_sdat(i2c_sdat2));

  always #5 clk = ~clk;

  // Free-running cycle counter used for SCL period measurement
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] tbl_word(input int e);
    case (e)
      0:       return 16'h0C62;
      1:       return 16'h0E03;
      2:       return 16'h1201;
      default: return 16'h0000;
    endcase
  endfunction

  // External table, combinational from tbl_index
  always_comb tbl_data = tbl_word(int'(tbl_index));

  // ---------------- bus monitor and slave ----------------
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         bitn = 0, bytn = 0, n_start = 0, n_stop = 0;
  int         last_rise = 0, rise_gap = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  int         nack_entry = 0, nack_byte = 0, nack_left = 0;

  // Decode START/STOP/bits at the negative clock edge and drive the ACK
  always @(negedge clk) begin
    logic s, d, nk;
    s = i2c_sclk;
    d = i2c_sdat;
    if (p_scl && s && p_sda && !d) begin
      n_start++; bitn = 0; bytn = 0; slave_low = 1'b0;
    end else if (p_scl && s && !p_sda && d) begin
      n_stop++;
    end else if (!p_scl && s) begin
      rise_gap  = cyc - last_rise;
      last_rise = cyc;
      if (bitn < 8) begin
        sh = {sh[6:0], d};
        bitn++;
        if (bitn == 8) log_q.push_back(sh);
      end else begin
        bitn = 0;
        bytn++;
      end
    end else if (p_scl && !s) begin
      if (bitn == 8) begin
        nk = (nack_left != 0) && (int'(tbl_index) == nack_entry) && (bytn == nack_byte);
        if (nk && nack_left > 0) nack_left--;
        slave_low = !nk;
      end else begin
        slave_low = 1'b0;
      end
    end
    p_scl = s;
    p_sda = d;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic eb, input logic ed, input logic ee,
                         input logic es, input logic ea, input logic [3:0] ei);
    chk({tag, " busy"},  {31'd0, busy},     {31'd0, eb});
    chk({tag, " done"},  {31'd0, done},     {31'd0, ed});
    chk({tag, " error"}, {31'd0, error},    {31'd0, ee});
    chk({tag, " scl"},   {31'd0, i2c_sclk}, {31'd0, es});
    chk({tag, " sda"},   {31'd0, i2c_sdat}, {31'd0, ea});
    chk({tag, " idx"},   {28'd0, tbl_index}, {28'd0, ei});
  endtask

  task automatic wait_to(input int n);
    repeat (n - cur) @(posedge clk);
    cur = n;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic add_frame(input int e);
    logic [15:0] w;
    w = tbl_word(e);
    exp_q.push_back(8'h34);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic cmp_log(input string tag, input int e_start, input int e_stop);
    chk({tag, " nbytes"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), {24'd0, log_q[i]}, {24'd0, exp_q[i]});
    chk({tag, " starts"}, n_start, e_start);
    chk({tag, " stops"},  n_stop,  e_stop);
  endtask

  task automatic clear_mon();
    log_q.delete();
    exp_q.delete();
    n_start = 0;
    n_stop  = 0;
  endtask

  typedef struct {
    int       cyc;
    bit       pulse;
    logic     busy, done, err, scl, sda;
    logic [3:0] idx;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0;

    // cycle offsets are relative to the first edge after reset release
    vecs.push_back('{0,    0, 1, 0, 0, 1, 1, 4'd0});
    vecs.push_back('{4,    0, 1, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{8,    0, 1, 0, 0, 0, 0, 4'd0});
    vecs.push_back('{16,   0, 1, 0, 0, 0, 0, 4'd0});
    vecs.push_back('{20,   0, 1, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{48,   0, 1, 0, 0, 0, 1, 4'd0});
    vecs.push_back('{52,   0, 1, 0, 0, 1, 1, 4'd0});
    vecs.push_back('{110,  0, 1, 0, 0, 0, 1, 4'd0});
    vecs.push_back('{152,  0, 1, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{448,  0, 1, 0, 0, 0, 0, 4'd0});
    vecs.push_back('{452,  0, 1, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{456,  0, 1, 0, 0, 1, 1, 4'd0});
    vecs.push_back('{470,  0, 1, 0, 0, 1, 1, 4'd0});
    vecs.push_back('{480,  0, 1, 0, 0, 1, 1, 4'd1});
    vecs.push_back('{600,  1, 1, 0, 0, 1, 0, 4'd1});
    vecs.push_back('{690,  0, 1, 0, 0, 0, 0, 4'd1});
    vecs.push_back('{708,  0, 1, 0, 0, 1, 1, 4'd1});
    vecs.push_back('{1000, 0, 1, 0, 0, 1, 0, 4'd2});
    vecs.push_back('{1439, 0, 1, 0, 0, 1, 1, 4'd2});
    vecs.push_back('{1440, 0, 0, 1, 0, 1, 1, 4'd2});
    vecs.push_back('{1450, 1, 0, 1, 0, 1, 1, 4'd2});
    vecs.push_back('{1451, 0, 1, 0, 0, 1, 1, 4'd0});
    vecs.push_back('{1455, 0, 1, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{1931, 0, 1, 0, 0, 1, 1, 4'd1});
    vecs.push_back('{2890, 0, 1, 0, 0, 1, 1, 4'd2});
    vecs.push_back('{2891, 0, 0, 1, 0, 1, 1, 4'd2});

    repeat (3) @(negedge clk);
    chk_bus("reset", 0, 0, 0, 1, 1, 4'd0);
    chk("reset err_index", {28'd0, err_index}, 32'd0);

    // full ACKed table, mid-run start ignored, restart after done
    reset_n = 1'b1;
    cur = -1;
    foreach (vecs[i]) begin
      wait_to(vecs[i].cyc);
      chk_bus($sformatf("vec%0d@%0d", i, vecs[i].cyc), vecs[i].busy, vecs[i].done,
              vecs[i].err, vecs[i].scl, vecs[i].sda, vecs[i].idx);
      if (vecs[i].cyc == 110) chk("scl period", rise_gap, 32'd16);
      if (vecs[i].pulse) begin
        pulse_start();
        cur = cur + 1;
      end
    end
    for (int r = 0; r < 2; r++)
      for (int e = 0; e < 3; e++) add_frame(e);
    cmp_log("run1", 6, 6);

    // asynchronous reset in the middle of BIT slot 14
    wait_to(2900);
    pulse_start();
    cur = 0;
    wait_to(241);
    chk_bus("pre-reset", 1, 0, 0, 0, 1, 4'd0);
    reset_n = 1'b0;
    #1;
    chk_bus("async reset", 0, 0, 0, 1, 1, 4'd0);
    repeat (3) @(negedge clk);
    clear_mon();
    slave_low  = 1'b0;
    nack_entry = 0; nack_byte = 0; nack_left = 1;

    // auto restart after release, address byte of entry 0 NACKed once
    reset_n = 1'b1;
    cur = -1;
    wait_to(152); chk_bus("nack q2",    1, 0, 0, 1, 1, 4'd0);
    wait_to(156); chk_bus("nack q3",    1, 0, 0, 0, 1, 4'd0);
    wait_to(160); chk_bus("abort stop0", 1, 0, 0, 0, 0, 4'd0);
    wait_to(164); chk_bus("abort stop1", 1, 0, 0, 1, 0, 4'd0);
    wait_to(168); chk_bus("abort stop2", 1, 0, 0, 1, 1, 4'd0);
    wait_to(180); chk_bus("abort gap",   1, 0, 0, 1, 1, 4'd0);
    wait_to(192); chk_bus("retry start", 1, 0, 0, 1, 1, 4'd0);
    wait_to(196); chk_bus("retry q1",    1, 0, 0, 1, 0, 4'd0);
    wait_to(1631); chk_bus("retry end-1", 1, 0, 0, 1, 1, 4'd2);
    wait_to(1632); chk_bus("retry done",  0, 1, 0, 1, 1, 4'd2);
    exp_q.push_back(8'h34);
    for (int e = 0; e < 3; e++) add_frame(e);
    cmp_log("retry", 4, 4);

    // data byte of entry 1 always NACKed: retries exhausted
    wait_to(1640);
    clear_mon();
    nack_entry = 1; nack_byte = 2; nack_left = -1;
    pulse_start();
    cur = 0;
    wait_to(0);    chk_bus("err launch", 1, 0, 0, 1, 1, 4'd0);
    wait_to(480);  chk_bus("err try1",   1, 0, 0, 1, 1, 4'd1);
    wait_to(960);  chk_bus("err try2",   1, 0, 0, 1, 1, 4'd1);
    wait_to(1440); chk_bus("err try3",   1, 0, 0, 1, 1, 4'd1);
    wait_to(1919); chk_bus("err end-1",  1, 0, 0, 1, 1, 4'd1);
    wait_to(1920); chk_bus("err final",  0, 0, 1, 1, 1, 4'd1);
    chk("err_index", {28'd0, err_index}, 32'd1);
    wait_to(2500); chk_bus("err hold",   0, 0, 1, 1, 1, 4'd1);
    add_frame(0);
    for (int k = 0; k < 3; k++) add_frame(1);
    cmp_log("error", 4, 4);

    // manual-start instance stays idle until its first start pulse
    chk("man idle scl",  {31'd0, i2c_sclk2}, 32'd1);
    chk("man idle sda",  {31'd0, i2c_sdat2}, 32'd1);
    chk("man idle busy", {31'd0, busy2},     32'd0);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    chk("man busy", {31'd0, busy2}, 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("man start sda", {31'd0, i2c_sdat2}, 32'd0);
    chk("man start scl", {31'd0, i2c_sclk2}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_cfg_seq.md
Name: i2c_cfg_seq

Overview:
Parametrised I2C configuration sequencer. It walks an external register table of NUM_ENTRIES 16-bit words and writes each word to one I2C slave as a 3-byte frame: device address+W, table[15:8], table[7:0]. Compared with the first-generation codec controller it adds:
- a parametrised bus rate and table depth;
- a proper STOP condition;
- a bounded retry count and error reporting;
- a re-triggerable start.

It sits between a board-level config table (codec, video DAC, etc.) and the shared I2C pins.

Parameters:
- DIV, 125: clk cycles per quarter SCL period; SCL = clk/(4*DIV), so 100 kHz at 50 MHz.
- NUM_ENTRIES, 10: number of table words to send (1..2^IDX_W).
- IDX_W, 4: width of the table index.
- DEV_ADDR, 7'h1A: 7-bit slave address; the first byte on the wire is {DEV_ADDR,0} = 8'h34.
- MAX_RETRY, 3: retries allowed per entry after a NACK; total attempts = MAX_RETRY+1.
- AUTO_START, 1: 1 = sequence launches by itself on the first clk after reset release.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  one-cycle pulse; launches the sequence from index 0
- busy  out  1  high while a sequence is running
- done  out  1  level; the whole table was written successfully
- error  out  1  level; an entry exhausted its retries
- err_index  out  IDX_W  index of the failing entry (valid while error=1)
- tbl_index  out  IDX_W  address into the external table
- tbl_data  in  16  table word {sub-address, data}; combinational from tbl_index
- i2c_sclk  out  1  SCL, push-pull
- i2c_sdat  inout  1  SDA, open-drain: drives 0 or Z, never drives 1

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. During reset:
  - busy=0, done=0, error=0, err_index=0, tbl_index=0.
  - i2c_sclk=1, SDA released (Z).
  - Quarter-tick counter and retry counter cleared.
  - All of this takes effect immediately, including mid-frame; no STOP is emitted.
- Tick generator: 0..DIV-1 counter, runs only when the FSM is not in IDLE/DONE/ERROR. tick = 1-cycle pulse at terminal count. All bus activity advances on tick. Each bus phase below lasts 1 tick (quarter period).
- FSM states: IDLE, START, BIT, STOP, GAP, DONE, ERROR.
- IDLE:
  - On start (or the first cycle after reset when AUTO_START=1): busy=1 next clk; clear done, error, retry counter and tbl_index; go to START.
- START:
  - q0: SDA=Z, SCL=1.
  - q1: SDA=0.
  - q2: SCL=0.
  - q3: hold.
  - tbl_data is latched into a 24-bit shift register {DEV_ADDR,0,tbl_data} at q0.
- BIT: 27 bit slots (3 bytes x 9), MSB first.
  - q0: SCL=0, SDA = bit (0 → drive 0, 1 → Z).
  - q1: SCL=1.
  - q2: SCL=1; in ACK slots (9th bit) SDA is Z and the line is sampled here.
  - q3: SCL=0.
  - A sampled 1 in an ACK slot is a NACK: abort the remaining slots immediately after q3 and go to STOP with nack flag set.
- STOP:
  - q0: SDA=0, SCL=0.
  - q1: SCL=1.
  - q2: SDA=Z.
  - q3: hold.
- GAP: 4 ticks of bus idle (SCL=1, SDA=Z), then branch:
  - nack and retry_cnt < MAX_RETRY: retry_cnt+1, same tbl_index, go to START.
  - nack and retry_cnt == MAX_RETRY: error=1, err_index=tbl_index, busy=0, go to ERROR.
  - ack and tbl_index == NUM_ENTRIES-1: done=1, busy=0, go to DONE.
  - ack otherwise: tbl_index+1, retry_cnt=0, go to START.
- Frame timing: a full ACKed frame is 120 ticks (START 4 + BIT 108 + STOP 4 + GAP 4).
- tbl_index is stable from the START of one frame until GAP completes.
- start pulse:
  - While busy=1: ignored.
  - In DONE or ERROR: restarts exactly as from IDLE (flags cleared the next clk).
  - start in the same cycle as a tick: start has no effect unless the FSM is idle.
- Index width: tbl_index never exceeds NUM_ENTRIES-1; no wrap-around.
- NUM_ENTRIES=1 is legal.

Test Plan:
1. DIV=4, NUM_ENTRIES=3, slave ACKs all, table {0C62,0E03,1201} → three frames on the wire: 34 0C 62, 34 0E 03, 34 12 01. Each frame has a START, a STOP, and SCL period 16 clk. done=1 and busy=0 after 360 ticks (1440 clk); error=0.
2. Slave NACKs the address byte once at entry 0 → frame aborts after slot 9, STOP, GAP, then entry 0 is resent; tbl_index stays 0 during the retry; sequence completes with done=1.
3. MAX_RETRY=2, slave NACKs the data byte of entry 1 every time → exactly 3 attempts on entry 1, then error=1, err_index=1, done=0, busy=0; entry 2 is never sent.
4. start pulsed mid-sequence → no effect. start pulsed after done → busy=1 next clk, done=0, tbl_index=0, table resent in full.
5. reset_n asserted during BIT slot 14 → same clk edge: i2c_sclk=1, SDA=Z, busy=0. With AUTO_START=1 the sequence restarts from index 0 after release.
6. AUTO_START=0 → SCL stays 1 and SDA stays Z indefinitely after reset until the first start pulse.
